// File: rtl/mean_pkg.sv
// rtl/mean_pkg.sv - shared constants and types for the mean_sched slice
package mean_pkg;

  localparam int NCH_DEF      = 4;
  localparam int DW_DEF       = 8;
  localparam int LOG2_WIN_DEF = 7;
  localparam int WIN_DEF      = 1 << LOG2_WIN_DEF;

  // Running-sum width: WIN samples of DW bits never exceed this
  localparam int SUM_W = DW_DEF + LOG2_WIN_DEF;

  typedef logic [$clog2(NCH_DEF)-1:0] ch_t;

endpackage

// File: rtl/mean_rr_arb.sv
// rtl/mean_rr_arb.sv - round-robin one-hot arbiter with pointer advance on acceptance
module mean_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last_q;
  logic [IW-1:0] win_idx;

  // Search from the channel after the last grant; scanning backwards lets the nearest requester overwrite farther ones
  always_comb begin
    gnt     = '0;
    win_idx = last_q;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last_q) + i) % N]) begin
        gnt                            = '0;
        gnt[(int'(last_q) + i) % N]    = 1'b1;
        win_idx                        = IW'((int'(last_q) + i) % N);
      end
    end
  end

  // Priority pointer moves only when the offered grant was actually taken; reset gives channel 0 first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else if (advance) begin
      last_q <= win_idx;
    end
  end

endmodule

// File: rtl/mean_sched.sv
// rtl/mean_sched.sv - shared-datapath multi-channel moving-average scheduler (option: MEAN_SCHED_ROUND_EN)
module mean_sched
  import mean_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int WIN      = WIN_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*DW-1:0]      in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [DW-1:0]          out_data,
  output logic                   out_full
);

  localparam int CW    = $clog2(NCH);
  localparam int ACC_W = DW + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN);

  // The shift-based mean is only exact when the window is a power of two
  generate
    if (WIN != (1 << LOG2_WIN)) begin : g_bad_win
      $error("mean_sched: WIN must equal 2**LOG2_WIN");
    end
  endgenerate

  // Per-channel window state
  logic [DW-1:0]       win_buf [NCH][WIN];
  logic [LOG2_WIN-1:0] wptr_q  [NCH];
  logic [CNT_W-1:0]    cnt_q   [NCH];
  logic [ACC_W-1:0]    sum_q   [NCH];

  // Shared datapath signals for the granted channel
  logic              accept;
  logic [CW-1:0]     sel;
  logic [DW-1:0]     x;
  logic [DW-1:0]     old;
  logic [ACC_W-1:0]  cur_sum;
  logic [ACC_W-1:0]  nsum;
  logic              full;
  logic [DW-1:0]     mean;

  mean_rr_arb #(
    .N (NCH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (accept),
    .gnt     (in_ready)
  );

  assign accept = |(in_valid & in_ready);

  // One-hot mux of the granted channel's state, then the shared sum update; the evicted sample only counts once the window is full
  always_comb begin
    sel     = '0;
    x       = '0;
    old     = '0;
    cur_sum = '0;
    full    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (in_ready[c]) begin
        sel     = CW'(c);
        x       = in_data[c*DW +: DW];
        cur_sum = sum_q[c];
        full    = (cnt_q[c] == WIN_CNT);
        old     = full ? win_buf[c][wptr_q[c]] : '0;
      end
    end
    nsum = cur_sum + ACC_W'(x) - ACC_W'(old);
  end

`ifdef MEAN_SCHED_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (LOG2_WIN - 1);
  logic [ACC_W:0] rsum;

  // Round half up with one guard bit, clamping the rare carry past DW bits
  always_comb begin
    rsum = {1'b0, nsum} + HALF;
    mean = rsum[ACC_W] ? '1 : rsum[ACC_W-1 -: DW];
  end
`else
  // Truncating mean: drop the LOG2_WIN fraction bits
  always_comb begin
    mean = nsum[ACC_W-1 -: DW];
  end
`endif

  // Sum, write pointer and fill counter of the granted channel only; other channels hold
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end else if (accept && in_ready[c]) begin
        sum_q[c]  <= nsum;
        wptr_q[c] <= wptr_q[c] + 1'b1;
        if (cnt_q[c] != WIN_CNT) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Sample storage; no reset needed since the fill counter gates every read
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      win_buf[sel][wptr_q[sel]] <= x;
    end
  end

  // Result register: one strobe per accepted sample, fields held between results
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_ch   <= sel;
        out_data <= mean;
        out_full <= full;
      end
    end
  end

endmodule

// File: tb/tb_mean_sched.sv
// tb/tb_mean_sched.sv - directed self-checking bench for mean_sched
module tb_mean_sched;
  import mean_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  ch_t               out_ch;
  logic [DW-1:0]     out_data;
  logic              out_full;

  int checks   = 0;
  int failures = 0;

  mean_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_full  (out_full)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_mean(input int s);
`ifdef MEAN_SCHED_ROUND_EN
    int r;
    r = (s + 64) >> 7;
    return (r > 255) ? 255 : r;
`else
    return s >> 7;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ch, input int data, input int full);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_ch"},    32'(out_ch),    ch);
    chk({tag, "_data"},  32'(out_data),  data);
    chk({tag, "_full"},  32'(out_full),  full);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send1(input int ch, input int val);
    in_valid             = NCH'(1 << ch);
    in_data[ch*DW +: DW] = DW'(val);
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  int ev1 [6] = '{1, 1, 0, 1, 1, 0};
  int erdy[6] = '{1, 2, 1, 2, 1, 1};
  int ech [6] = '{0, 1, 0, 1, 0, 0};
  int edat[6] = '{1, 1, 2, 2, 3, 4};

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ch",    32'(out_ch),    0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_full",  32'(out_full),  0);
    in_valid = 4'hF; #1;
    chk("rst_rdy_all", 32'(in_ready), 1);
    in_valid = 4'b0110; #1;
    chk("rst_rdy_12", 32'(in_ready), 2);
    in_valid = '0;
    rst = 1'b0;

    // Channel 0 fill ramp and saturation of the window
    do_reset();
    in_data[7:0] = 8'd128;
    for (int n = 1; n <= 130; n++) begin
      in_valid = 4'b0001; #1;
      chk("t1_rdy", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk_out($sformatf("t1_n%0d", n), 0, exp_mean(((n > 128) ? 128 : n) * 128), (n >= 129) ? 1 : 0);
    end
    in_valid = '0;
    @(posedge clk); #1;
    chk("t1_idle", 32'(out_valid), 0);

    // All channels requesting: strict rotation, independent means
    do_reset();
    in_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    in_valid = 4'hF;
    for (int k = 0; k < 516; k++) begin
      int ch, n, v;
      ch = k % 4;
      n  = k / 4 + 1;
      v  = (ch + 1) * 10;
      #1;
      chk("t2_rdy", 32'(in_ready), 32'(1 << ch));
      @(posedge clk); #1;
      chk_out($sformatf("t2_k%0d", k), ch, exp_mean(((n > 128) ? 128 : n) * v), (n > 128) ? 1 : 0);
    end
    in_valid = '0;

    // Channel 1 fill then decay; channel 2 must be untouched
    do_reset();
    send1(2, 200); chk_out("t3_c2a", 2, exp_mean(200), 0);
    send1(2, 200); chk_out("t3_c2b", 2, exp_mean(400), 0);
    for (int n = 1; n <= 128; n++) begin
      send1(1, 124);
      chk_out($sformatf("t3_fill%0d", n), 1, exp_mean(n * 124), 0);
    end
    for (int m = 1; m <= 128; m++) begin
      send1(1, 0);
      chk_out($sformatf("t3_decay%0d", m), 1, exp_mean((128 - m) * 124), 1);
    end
    chk("t3_end0", 32'(out_data), 0);
    send1(2, 200); chk_out("t3_c2c", 2, exp_mean(600), 0);

    // Rounding boundary and full-scale window without wrap
    do_reset();
    send1(3, 64);
`ifdef MEAN_SCHED_ROUND_EN
    chk_out("t4_single", 3, 1, 0);
`else
    chk_out("t4_single", 3, 0, 0);
`endif
    for (int n = 1; n <= 130; n++) begin
      send1(2, 255);
      if (n >= 128) chk_out($sformatf("t4_max%0d", n), 2, 255, (n > 128) ? 1 : 0);
    end

    // Mid-stream reset clears state and discards the reset-cycle sample
    do_reset();
    for (int n = 1; n <= 50; n++) send1(3, 100);
    chk_out("t5_pre", 3, exp_mean(5000), 0);
    rst = 1'b1;
    in_valid = 4'b1000;
    in_data[31:24] = 8'd100;
    @(posedge clk); #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_data",  32'(out_data),  0);
    rst = 1'b0;
    in_valid = '0;
    send1(3, 128);
    chk_out("t5_after", 3, 1, 0);

    // Channel 0 steady, channel 1 intermittent
    do_reset();
    in_data[7:0]  = 8'd128;
    in_data[15:8] = 8'd128;
    for (int i = 0; i < 6; i++) begin
      in_valid = {2'b00, ev1[i][0], 1'b1}; #1;
      chk($sformatf("t6_rdy%0d", i), 32'(in_ready), erdy[i]);
      @(posedge clk); #1;
      chk_out($sformatf("t6_out%0d", i), ech[i], edat[i], 0);
    end
    in_valid = '0;
    @(posedge clk); #1;
    chk("t6_idle", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
